// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle for the multicycle RV32I controller: instruction fields
// and ALU/memory status in, datapath strobes and mux selects out.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       aluZero;
  logic       aluLt;
  logic       memReady;
  logic       pcWrite;
  logic       irWrite;
  logic       regWrite;
  logic       memRead;
  logic       memWrite;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [3:0] aluOp;
  logic       pcSrc;
  logic [1:0] resultSel;
  logic [3:0] state;
  logic       illegal;

  modport master (
    input  opcode, funct3, funct7b5, aluZero, aluLt, memReady,
    output pcWrite, irWrite, regWrite, memRead, memWrite,
           aluSrcA, aluSrcB, aluOp, pcSrc, resultSel, state, illegal
  );

  modport slave (
    output opcode, funct3, funct7b5, aluZero, aluLt, memReady,
    input  pcWrite, irWrite, regWrite, memRead, memWrite,
           aluSrcA, aluSrcB, aluOp, pcSrc, resultSel, state, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core (fetch/decode/execute/mem/writeback).
// Define MC_CTRL_TRAP_EN to lock illegal opcodes in a TRAP state until reset.
module multicycle_ctrl (
  input  logic             clk,
  input  logic             rst_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXECR  = 4'd6,  EXECI  = 4'd7,
    ALUWB  = 4'd8,  BRANCH = 4'd9,  JAL    = 4'd10, JALR   = 4'd11,
    LUI    = 4'd12, TRAP   = 4'd15
  } stateT;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  stateT st, stNext;
  logic  opLegal;

  // funct7b5 selects SUB only for register ops; shifts honour it in both forms
  function automatic logic [3:0] aluDecode(input logic [2:0] f3, input logic f7, input logic isReg);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (isReg && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    opLegal = 1'b0;
    case (bus.opcode)
      OP_LOAD, OP_STORE, OP_REG, OP_IMM, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opLegal = 1'b1;
      default:                           opLegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) st <= FETCH;
    else        st <= stNext;
  end

  always_comb begin
    stNext = st;
    case (st)
      FETCH:  stNext = bus.memReady ? DECODE : FETCH;
      DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: stNext = MEMADR;
          OP_REG:            stNext = EXECR;
          OP_IMM:            stNext = EXECI;
          OP_BRANCH:         stNext = BRANCH;
          OP_JAL:            stNext = JAL;
          OP_JALR:           stNext = JALR;
          OP_LUI, OP_AUIPC:  stNext = LUI;
`ifdef MC_CTRL_TRAP_EN
          default:           stNext = TRAP;
`else
          default:           stNext = FETCH;
`endif
        endcase
      end
      MEMADR: stNext = (bus.opcode == OP_STORE) ? MEMWR : MEMRD;
      MEMRD:  stNext = bus.memReady ? MEMWB : MEMRD;
      MEMWR:  stNext = bus.memReady ? FETCH : MEMWR;
      EXECR, EXECI, LUI: stNext = ALUWB;
`ifdef MC_CTRL_TRAP_EN
      TRAP:   stNext = TRAP;
`else
      TRAP:   stNext = FETCH;
`endif
      default: stNext = FETCH;
    endcase
  end

  // Outputs are held at zero while reset is asserted so nothing fires mid-abandon
  always_comb begin
    bus.pcWrite   = 1'b0;
    bus.irWrite   = 1'b0;
    bus.regWrite  = 1'b0;
    bus.memRead   = 1'b0;
    bus.memWrite  = 1'b0;
    bus.aluSrcA   = 1'b0;
    bus.aluSrcB   = 2'b00;
    bus.aluOp     = ALU_ADD;
    bus.pcSrc     = 1'b0;
    bus.resultSel = 2'b00;
    bus.illegal   = 1'b0;
    if (rst_n) begin
      case (st)
        FETCH: begin
          bus.memRead = 1'b1;
          bus.aluSrcA = 1'b1;
          bus.aluSrcB = 2'b01;
          bus.irWrite = bus.memReady;
          bus.pcWrite = bus.memReady;
        end
        DECODE: begin
          bus.aluSrcA = 1'b1;
          bus.aluSrcB = 2'b10;
`ifndef MC_CTRL_TRAP_EN
          bus.illegal = !opLegal;
`endif
        end
        MEMADR: bus.aluSrcB = 2'b10;
        MEMRD:  bus.memRead = 1'b1;
        MEMWB: begin
          bus.regWrite  = 1'b1;
          bus.resultSel = 2'b01;
        end
        MEMWR:  bus.memWrite = 1'b1;
        EXECR:  bus.aluOp = aluDecode(bus.funct3, bus.funct7b5, 1'b1);
        EXECI: begin
          bus.aluSrcB = 2'b10;
          bus.aluOp   = aluDecode(bus.funct3, bus.funct7b5, 1'b0);
        end
        ALUWB:  bus.regWrite = 1'b1;
        BRANCH: begin
          // funct3[2] picks compare vs equality, funct3[1] unsigned, funct3[0] inverts
          if (!bus.funct3[2])     bus.aluOp = ALU_SUB;
          else if (!bus.funct3[1]) bus.aluOp = ALU_SLT;
          else                     bus.aluOp = ALU_SLTU;
          bus.pcWrite = bus.funct3[2] ? (bus.aluLt ^ bus.funct3[0])
                                      : (bus.aluZero ^ bus.funct3[0]);
          bus.pcSrc   = 1'b1;
        end
        JAL: begin
          bus.pcWrite   = 1'b1;
          bus.pcSrc     = 1'b1;
          bus.regWrite  = 1'b1;
          bus.resultSel = 2'b10;
        end
        JALR: begin
          bus.aluSrcB   = 2'b10;
          bus.pcWrite   = 1'b1;
          bus.regWrite  = 1'b1;
          bus.resultSel = 2'b10;
        end
        LUI: begin
          bus.aluSrcB = 2'b10;
          if (bus.opcode == OP_AUIPC) bus.aluSrcA = 1'b1;
          else                        bus.aluOp   = ALU_PASSB;
        end
`ifdef MC_CTRL_TRAP_EN
        TRAP:   bus.illegal = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign bus.state = st;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: each instruction is expanded into its
// expected cycle-by-cycle trace from the instruction-class timing rules.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       pcW, irW, regW, mRd, mWr, srcA;
    logic [1:0] srcB;
    logic [3:0] op;
    logic       pcS;
    logic [1:0] res;
    logic       ill;
  } obsT;

  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic       f7, zero, lt, rdy;
    obsT        exp;
  } cycT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  cycT cyc[$];
  logic [6:0] cOpc;
  logic [2:0] cF3;
  logic cF7, cZ, cLt;
  int cycNum = 0;

  function automatic obsT mk(input int st, input bit pcW, irW, regW, mRd, mWr, srcA,
                             input int srcB, op, input bit pcS, input int res, input bit ill);
    obsT o;
    o.st = 4'(st); o.pcW = pcW; o.irW = irW; o.regW = regW; o.mRd = mRd; o.mWr = mWr;
    o.srcA = srcA; o.srcB = 2'(srcB); o.op = 4'(op); o.pcS = pcS; o.res = 2'(res); o.ill = ill;
    return o;
  endfunction

  function automatic obsT observe();
    obsT o;
    o.st = bus.state; o.pcW = bus.pcWrite; o.irW = bus.irWrite; o.regW = bus.regWrite;
    o.mRd = bus.memRead; o.mWr = bus.memWrite; o.srcA = bus.aluSrcA; o.srcB = bus.aluSrcB;
    o.op = bus.aluOp; o.pcS = bus.pcSrc; o.res = bus.resultSel; o.ill = bus.illegal;
    return o;
  endfunction

  // Expected ALU operation named by mnemonic: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND
  function automatic int aluFor(input logic [2:0] f3, input logic f7, input bit isReg);
    case (f3)
      3'd0: return (isReg && f7) ? 1 : 0;
      3'd1: return 7;
      3'd2: return 5;
      3'd3: return 6;
      3'd4: return 4;
      3'd5: return f7 ? 9 : 8;
      3'd6: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic push(input logic rdy, input obsT e);
    cycT c;
    c.opc = cOpc; c.f3 = cF3; c.f7 = cF7; c.zero = cZ; c.lt = cLt; c.rdy = rdy; c.exp = e;
    cyc.push_back(c);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic addInstr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                          input logic z, input logic lt, input int wF, input int wM);
    bit bad, taken;
    int op;
    cOpc = opc; cF3 = f3; cF7 = f7; cZ = z; cLt = lt;
    bad = !(opc inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                        7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111});
    for (int i = 0; i < wF; i++) push(1'b0, mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
    push(1'b1, mk(0, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0));
`ifdef MC_CTRL_TRAP_EN
    push(rnd(), mk(1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
`else
    push(rnd(), mk(1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, bad));
`endif
    case (opc)
      7'b0000011: begin
        push(rnd(), mk(2, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        for (int i = 0; i < wM; i++) push(1'b0, mk(3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        push(1'b1, mk(3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        push(rnd(), mk(4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
      end
      7'b0100011: begin
        push(rnd(), mk(2, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        for (int i = 0; i < wM; i++) push(1'b0, mk(5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        push(1'b1, mk(5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      end
      7'b0110011, 7'b0010011: begin
        if (opc == 7'b0110011)
          push(rnd(), mk(6, 0, 0, 0, 0, 0, 0, 0, aluFor(f3, f7, 1), 0, 0, 0));
        else
          push(rnd(), mk(7, 0, 0, 0, 0, 0, 0, 2, aluFor(f3, f7, 0), 0, 0, 0));
        push(rnd(), mk(8, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      7'b1100011: begin
        case (f3)
          3'd0: begin op = 1; taken = z;   end  // BEQ
          3'd1: begin op = 1; taken = !z;  end  // BNE
          3'd4: begin op = 5; taken = lt;  end  // BLT
          3'd5: begin op = 5; taken = !lt; end  // BGE
          3'd6: begin op = 6; taken = lt;  end  // BLTU
          default: begin op = 6; taken = !lt; end  // BGEU
        endcase
        push(rnd(), mk(9, taken, 0, 0, 0, 0, 0, 0, op, 1, 0, 0));
      end
      7'b1101111: push(rnd(), mk(10, 1, 0, 1, 0, 0, 0, 0, 0, 1, 2, 0));
      7'b1100111: push(rnd(), mk(11, 1, 0, 1, 0, 0, 0, 2, 0, 0, 2, 0));
      7'b0110111: begin
        push(rnd(), mk(12, 0, 0, 0, 0, 0, 0, 2, 10, 0, 0, 0));
        push(rnd(), mk(8, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      7'b0010111: begin
        push(rnd(), mk(12, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
        push(rnd(), mk(8, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      default: begin
`ifdef MC_CTRL_TRAP_EN
        for (int i = 0; i < 4; i++) push(rnd(), mk(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
`endif
      end
    endcase
  endtask

  task automatic check(input string tag, input obsT got, input obsT exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs up to n queued cycles (n < 0 runs the whole queue); starts just after a posedge
  task automatic runCycles(input int n);
    cycT c;
    int k = 0;
    while (cyc.size() > 0 && (n < 0 || k < n)) begin
      c = cyc.pop_front();
      bus.opcode = c.opc; bus.funct3 = c.f3; bus.funct7b5 = c.f7;
      bus.aluZero = c.zero; bus.aluLt = c.lt; bus.memReady = c.rdy;
      @(negedge clk);
      check($sformatf("cyc%0d_st%0d", cycNum, c.exp.st), observe(), c.exp);
      @(posedge clk); #1;
      cycNum++;
      k++;
    end
  endtask

  task automatic pulseReset(input string tag);
    obsT o;
    rst_n = 1'b0;
    bus.memReady = 1'b1;
    @(negedge clk);
    o = observe();
    checks++;
    assert ({o.pcW, o.irW, o.regW, o.mRd, o.mWr} === 5'b0) else begin
      errors++;
      $error("FAIL %s_strobes: got %b expected 00000", tag, {o.pcW, o.irW, o.regW, o.mRd, o.mWr});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0] legal [9];
    logic [2:0] brF3 [6];
    int pick;
    logic [6:0] opc;
    logic [2:0] f3;
    legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    brF3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    bus.opcode = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0;
    bus.aluZero = 1'b0; bus.aluLt = 1'b0; bus.memReady = 1'b1;

    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_state", observe(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    addInstr(7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);  // ADD
    addInstr(7'b0110011, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0);  // SUB
    addInstr(7'b0010011, 3'd5, 1'b1, 1'b0, 1'b0, 0, 0);  // SRAI
    addInstr(7'b0010011, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0);  // ADDI with bit30 set
    addInstr(7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 0, 3);  // LW, 3 wait cycles
    addInstr(7'b1100011, 3'd0, 1'b0, 1'b1, 1'b0, 0, 0);  // BEQ taken
    addInstr(7'b1100011, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);  // BEQ not taken
    addInstr(7'b1100011, 3'd7, 1'b0, 1'b0, 1'b0, 0, 0);  // BGEU taken
    addInstr(7'b1101111, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);  // JAL
    addInstr(7'b0010111, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);  // AUIPC
    addInstr(7'b0110111, 3'd0, 1'b0, 1'b0, 1'b0, 2, 0);  // LUI with fetch wait
    addInstr(7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, 1, 2);  // SW with waits
    addInstr(7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);  // JALR
    runCycles(-1);

    for (int n = 0; n < 80; n++) begin
      pick = $urandom_range(0, 8);
      opc = legal[pick];
      f3 = (opc == 7'b1100011) ? brF3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      addInstr(opc, f3, rnd(), rnd(), rnd(), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    runCycles(-1);

    // Reset in the middle of a stalled load: abandon it and restart at FETCH
    addInstr(7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 0, 5);
    runCycles(5);
    cyc.delete();
    pulseReset("midreset");
    addInstr(7'b0110011, 3'd4, 1'b0, 1'b0, 1'b0, 0, 0);
    runCycles(-1);

    addInstr(7'b0000000, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    runCycles(-1);
`ifdef MC_CTRL_TRAP_EN
    pulseReset("trapreset");
`endif
    addInstr(7'b0110011, 3'd7, 1'b0, 1'b0, 1'b0, 0, 0);
    runCycles(-1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
